ioff_scan_ctrl: RTL and testbench
=================================

// Module: ioff_scan_ctrl
// PURPOSE
//  Scan-chain controller that sits directly upstream of a chain of IO flip-flops.
//  It drives the chain's SI and SE inputs and its MODE_SEL input, and consumes
//  the chain's SO output. On each start request it shifts a parallel load word
//  into the chain and captures the previous chain contents into a readback word.
//  An optional one-cycle functional capture (SE=0) can run before the shift.
// PARAMETERS
//  CHAIN_LEN  32  number of IO flip-flops in the scan chain (>=2)
//  CNT_W      6   shift counter width; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  CK            in   1          clock; all state updates on the rising edge
//  global_reset  in   1          asynchronous reset, active-high
//  start         in   1          request pulse; sampled only in IDLE
//  cap_en        in   1          1 = perform a CAPTURE cycle before SHIFT; sampled with start
//  mode_sel_in   in   1          MODE_SEL value to apply to the chain; sampled with start
//  wdata         in   CHAIN_LEN  load word; sampled with start
//  scan_so       in   1          SO from the last flip-flop in the chain
//  scan_si       out  1          SI to the first flip-flop in the chain
//  scan_se       out  1          SE to all chain flip-flops
//  mode_sel      out  1          registered MODE_SEL to all chain flip-flops
//  busy          out  1          high from the cycle after an accepted start until done
//  done          out  1          one-cycle pulse after the last shift
//  rdata         out  CHAIN_LEN  readback word; stable from done until the next accepted start
// BEHAVIOUR
//  - All outputs are registered. On global_reset: state=IDLE; scan_si, scan_se,
//    mode_sel, busy and done = 0; rdata = 0; counter = 0.
//  - FSM states: IDLE, CAPTURE, SHIFT, DONE.
//    IDLE: start=1 latches wdata (into shreg), cap_en and mode_sel_in (into mode_sel),
//          then moves to CAPTURE if cap_en=1, otherwise to SHIFT.
//    CAPTURE: exactly 1 cycle with scan_se=0. The chain loads D. Next state is SHIFT.
//    SHIFT: exactly CHAIN_LEN cycles with scan_se=1. The counter runs 0..CHAIN_LEN-1.
//          In shift cycle k, scan_si = wdata[k] (LSB first).
//          At the closing edge of cycle k, rdata[k] <= scan_so.
//          When the counter reaches CHAIN_LEN-1, the next state is DONE.
//    DONE: 1 cycle with done=1, busy=0 and scan_se=0. Next state is IDLE.
//  - busy=1 in the CAPTURE and SHIFT states.
//  - scan_se=0 in every state other than SHIFT.
//  - scan_si=0 outside SHIFT.
//  - Latency from the accepted start edge to the done pulse: CHAIN_LEN+1 cycles,
//    or CHAIN_LEN+2 cycles when cap_en=1.
//  - A start asserted while not in IDLE (including DONE) is ignored; it is not queued.
//  - Input changes on wdata, cap_en or mode_sel_in after acceptance have no effect
//    until the next accepted start.
//  - mode_sel holds its latched value through reset-free operation.
//  - global_reset asserted mid-operation immediately forces scan_se=0 and busy=0,
//    and no done pulse is produced. The chain contents are then undefined.
//  - Counter wrap: the counter resets to 0 on entry to SHIFT. It never exceeds CHAIN_LEN-1.
// TESTING (bench uses CHAIN_LEN=8 and a behavioural 8-FF chain model)
//  1. Reset, then start with wdata=8'hA5, cap_en=0, chain preloaded with 8'h3C
//     -> scan_se high for exactly 8 cycles; rdata=8'h3C; chain holds 8'hA5;
//        done pulses at start+9.
//  2. Chain D inputs=8'h5A, cap_en=1, wdata=8'hFF
//     -> one cycle with scan_se=0 before the shift; rdata=8'h5A; done pulses at start+10.
//  3. start held high throughout an operation -> exactly one operation runs;
//     a second operation is accepted only on the first IDLE cycle after done.
//  4. global_reset asserted at shift cycle 4 -> scan_se=0, busy=0 and rdata=0
//     asynchronously; no done pulse occurs; the next start runs a full 8-cycle shift.
//  5. mode_sel_in=1 with start, then mode_sel_in=0 mid-shift -> mode_sel stays 1
//     until the next accepted start.
//  6. Back-to-back operations with wdata 8'h01 then 8'h80 -> the second rdata is 8'h01.

Source files
------------

// File: rtl/ioff_scan_ctrl_if.sv
// Host and scan-chain signal bundle for ioff_scan_ctrl.
// The master side is the host plus the chain's SO; the slave side is the controller.
interface ioff_scan_ctrl_if #(
    parameter int CHAIN_LEN = 32
);
    logic                 start;
    logic                 cap_en;
    logic                 mode_sel_in;
    logic [CHAIN_LEN-1:0] wdata;
    logic                 scan_so;
    logic                 scan_si;
    logic                 scan_se;
    logic                 mode_sel;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] rdata;

    modport master (
        output start, cap_en, mode_sel_in, wdata, scan_so,
        input  scan_si, scan_se, mode_sel, busy, done, rdata
    );

    modport slave (
        input  start, cap_en, mode_sel_in, wdata, scan_so,
        output scan_si, scan_se, mode_sel, busy, done, rdata
    );
endinterface

// File: rtl/ioff_scan_ctrl.sv
// Scan-chain controller for a chain of IO flip-flops: an optional functional capture,
// then a LSB-first shift of the load word while the old chain contents are read back.
module ioff_scan_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = 6
) (
    input  logic             CK,
    input  logic             global_reset,
    ioff_scan_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] shreg;

    // Outputs are set on the same edge as the state change that they belong to,
    // so scan_si/scan_se line up with the cycle the chain sees them in.
    always_ff @(posedge CK or posedge global_reset) begin
        if (global_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            bus.scan_si  <= 1'b0;
            bus.scan_se  <= 1'b0;
            bus.mode_sel <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rdata    <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.mode_sel <= bus.mode_sel_in;
                        bus.busy     <= 1'b1;
                        cnt          <= '0;
                        if (bus.cap_en) begin
                            state <= CAPTURE;
                            shreg <= bus.wdata;
                        end else begin
                            state       <= SHIFT;
                            bus.scan_se <= 1'b1;
                            bus.scan_si <= bus.wdata[0];
                            shreg       <= bus.wdata >> 1;
                        end
                    end
                end
                CAPTURE: begin
                    state       <= SHIFT;
                    cnt         <= '0;
                    bus.scan_se <= 1'b1;
                    bus.scan_si <= shreg[0];
                    shreg       <= shreg >> 1;
                end
                SHIFT: begin
                    // First bit out of the chain lands in rdata[0] after the last shift.
                    bus.rdata <= {bus.scan_so, bus.rdata[CHAIN_LEN-1:1]};
                    if (cnt == LAST) begin
                        state       <= DONE;
                        bus.scan_se <= 1'b0;
                        bus.scan_si <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        bus.scan_si <= shreg[0];
                        shreg       <= shreg >> 1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ioff_scan_ctrl.sv
// Directed bench for ioff_scan_ctrl with an 8-FF behavioural chain and an rdata scoreboard.
module tb_ioff_scan_ctrl;
    localparam int N = 8;

    logic CK = 1'b0;
    logic global_reset = 1'b1;

    ioff_scan_ctrl_if #(.CHAIN_LEN(N)) bus ();

    ioff_scan_ctrl #(.CHAIN_LEN(N), .CNT_W(4)) dut (
        .CK           (CK),
        .global_reset (global_reset),
        .bus          (bus)
    );

    always #5 CK = ~CK;

    // Chain model: SO is chain[0]; SI enters at the top, so after N shifts chain == load word.
    logic [N-1:0] chain;
    logic [N-1:0] chain_d;
    logic [N-1:0] pre_val;
    logic         preload_req;

    assign bus.scan_so = chain[0];

    always @(posedge CK) begin
        if (preload_req)      chain <= pre_val;
        else if (bus.scan_se) chain <= {bus.scan_si, chain[N-1:1]};
        else if (bus.busy)    chain <= chain_d;
    end

    logic [N-1:0] exp_q[$];
    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [N-1:0] v);
        @(negedge CK);
        pre_val     = v;
        preload_req = 1'b1;
        @(negedge CK);
        preload_req = 1'b0;
    endtask

    task automatic pop_rdata(input string tag);
        if (exp_q.size() > 0) check(tag, 32'(bus.rdata), 32'(exp_q.pop_front()));
        else check({tag, "_noexp"}, 32'(exp_q.size()), 32'd1);
    endtask

    // Runs one operation from the start cycle to the done cycle, disturbing the inputs mid-way.
    task automatic run_op(input logic [N-1:0] w, input logic cap, input logic msel,
                          input bit hold, input string nm);
        int           lat;
        int           se_n;
        int           done_at;
        logic [N-1:0] si_bits;
        lat     = cap ? N + 2 : N + 1;
        se_n    = 0;
        done_at = 0;
        si_bits = '0;
        @(negedge CK);
        bus.start       = 1'b1;
        bus.wdata       = w;
        bus.cap_en      = cap;
        bus.mode_sel_in = msel;
        exp_q.push_back(cap ? chain_d : chain);
        for (int cyc = 1; cyc <= 30 && done_at == 0; cyc++) begin
            @(negedge CK);
            if (cyc == 1) begin
                if (!hold) bus.start = 1'b0;
                check({nm, "_busy"}, 32'(bus.busy), 32'd1);
                check({nm, "_mode_sel"}, 32'(bus.mode_sel), 32'(msel));
                if (cap) check({nm, "_cap_se"}, 32'(bus.scan_se), 32'd0);
            end
            if (cyc == 4) begin
                bus.mode_sel_in = ~msel;
                bus.wdata       = ~w;
                bus.cap_en      = ~cap;
            end
            if (bus.scan_se) begin
                si_bits = {bus.scan_si, si_bits[N-1:1]};
                se_n++;
            end
            if (bus.done) done_at = cyc;
        end
        check({nm, "_latency"}, 32'(done_at), 32'(lat));
        check({nm, "_se_cycles"}, 32'(se_n), 32'(N));
        check({nm, "_si_bits"}, 32'(si_bits), 32'(w));
        check({nm, "_chain"}, 32'(chain), 32'(w));
        check({nm, "_busy_done"}, 32'(bus.busy), 32'd0);
        check({nm, "_mode_hold"}, 32'(bus.mode_sel), 32'(msel));
        pop_rdata({nm, "_rdata"});
        if (!hold) begin
            @(negedge CK);
            check({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        int dcount;
        int seen;
        bus.start       = 1'b0;
        bus.cap_en      = 1'b0;
        bus.mode_sel_in = 1'b0;
        bus.wdata       = '0;
        chain_d         = '0;
        pre_val         = '0;
        preload_req     = 1'b0;
        repeat (3) @(negedge CK);
        check("rst_se", 32'(bus.scan_se), 32'd0);
        check("rst_si", 32'(bus.scan_si), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_mode_sel", 32'(bus.mode_sel), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        global_reset = 1'b0;

        // Plain shift of A5 over a chain holding 3C.
        preload(8'h3C);
        run_op(8'hA5, 1'b0, 1'b0, 1'b0, "t1");

        // Functional capture of 5A then shift of FF.
        chain_d = 8'h5A;
        run_op(8'hFF, 1'b1, 1'b0, 1'b0, "t2");

        // mode_sel latched high survives mode_sel_in dropping; next start clears it.
        run_op(8'h33, 1'b0, 1'b1, 1'b0, "t5a");
        @(negedge CK);
        check("t5_mode_idle", 32'(bus.mode_sel), 32'd1);
        run_op(8'hCC, 1'b0, 1'b0, 1'b0, "t5b");

        // Back-to-back: second readback is the first load word.
        run_op(8'h01, 1'b0, 1'b0, 1'b0, "t6a");
        run_op(8'h80, 1'b0, 1'b0, 1'b0, "t6b");
        check("t6_rdata_const", 32'(bus.rdata), 32'h01);

        // start held high: ignored in DONE, accepted on the first IDLE cycle.
        run_op(8'h5C, 1'b0, 1'b0, 1'b1, "t3");
        bus.cap_en = 1'b0;
        bus.wdata  = 8'h3C;
        @(negedge CK);
        check("t3_idle_busy", 32'(bus.busy), 32'd0);
        check("t3_idle_done", 32'(bus.done), 32'd0);
        exp_q.push_back(chain);
        @(negedge CK);
        check("t3_accept", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            @(negedge CK);
            if (bus.done) seen = 1;
        end
        check("t3_second_done", 32'(seen), 32'd1);
        pop_rdata("t3_rdata");

        // Reset in shift cycle 4: immediate clear, no done, then a clean full operation.
        @(negedge CK);
        bus.start = 1'b1;
        bus.wdata = 8'h0F;
        exp_q.push_back(chain);
        @(negedge CK);
        bus.start = 1'b0;
        repeat (4) @(negedge CK);
        global_reset = 1'b1;
        #1;
        check("t4_se", 32'(bus.scan_se), 32'd0);
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_rdata", 32'(bus.rdata), 32'd0);
        void'(exp_q.pop_back());
        @(negedge CK);
        global_reset = 1'b0;
        dcount = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CK);
            if (bus.done || bus.busy) dcount++;
        end
        check("t4_no_done", 32'(dcount), 32'd0);
        preload(8'hC3);
        run_op(8'h96, 1'b0, 1'b0, 1'b0, "t4r");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
